// File: rtl/icache_refill_ctrl_if.sv
// ---------------------------------------------------------------------------
// icache_refill_ctrl_if
// Bundles the three handshakes of the I-cache refill controller: the fetch
// request/response pair, the cache probe/write port and the memory read port.
//   slave  : controller view (drives req_ready, resp_*, cache_addr/wdata/we,
//            mem_req_valid, mem_addr)
//   master : environment view (fetch stage, cache arrays, memory)
// Parameter DATA_WIDTH sets address and data width.
// ---------------------------------------------------------------------------
interface icache_refill_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] req_addr;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_err;

    logic [DATA_WIDTH-1:0] cache_addr;
    logic [DATA_WIDTH-1:0] cache_wdata;
    logic                  cache_we;
    logic                  cache_hit;
    logic [DATA_WIDTH-1:0] cache_rdata;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_addr, resp_ready,
        input  cache_hit, cache_rdata,
        input  mem_req_ready, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_err,
        output cache_addr, cache_wdata, cache_we,
        output mem_req_valid, mem_addr
    );

    modport master (
        output req_valid, req_addr, resp_ready,
        output cache_hit, cache_rdata,
        output mem_req_ready, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  cache_addr, cache_wdata, cache_we,
        input  mem_req_valid, mem_addr
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// icache_refill_ctrl
// Requester-side miss/refill controller for the instruction cache. Takes one
// fetch at a time, probes the cache, refills from memory on a miss through the
// cache write port and returns the instruction word (or an error on memory
// timeout).
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        icache_refill_ctrl_if.slave (fetch, cache and memory handshakes)
//   hit_count  saturating hit counter
//   miss_count saturating miss counter
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | ready for a fetch request
// LOOKUP   | one-cycle cache probe at addr_q
// MEM_REQ  | memory read request held until accepted
// MEM_WAIT | waiting for read data, bounded by the timeout timer
// FILL     | one-cycle cache write of the refilled word
// RESP     | response held until the fetch stage accepts it
// ---------------------------------------------------------------------------
module icache_refill_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    icache_refill_ctrl_if.slave   bus,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);
    localparam int TMR_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Down-counter spans exactly TIMEOUT_CYCLES wait cycles: load N-1, expire at 0.
    localparam logic [TMR_WIDTH-1:0] TMR_LOAD = TMR_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, MEM_REQ, MEM_WAIT, FILL, RESP
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [TMR_WIDTH-1:0]  timer;

    assign bus.cache_addr  = addr_q;
    assign bus.mem_addr    = addr_q;
    assign bus.cache_wdata = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            addr_q            <= '0;
            data_q            <= '0;
            timer             <= '0;
            bus.req_ready     <= 1'b1;
            bus.resp_valid    <= 1'b0;
            bus.resp_data     <= '0;
            bus.resp_err      <= 1'b0;
            bus.cache_we      <= 1'b0;
            bus.mem_req_valid <= 1'b0;
            hit_count         <= '0;
            miss_count        <= '0;
        end else begin
            bus.cache_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q        <= {bus.req_addr[DATA_WIDTH-1:2], 2'b00};
                        bus.req_ready <= 1'b0;
                        state         <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (bus.cache_hit) begin
                        bus.resp_data  <= bus.cache_rdata;
                        bus.resp_err   <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        if (hit_count != '1)
                            hit_count <= hit_count + CNT_WIDTH'(1);
                        state <= RESP;
                    end else begin
                        bus.mem_req_valid <= 1'b1;
                        if (miss_count != '1)
                            miss_count <= miss_count + CNT_WIDTH'(1);
                        state <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (bus.mem_req_ready) begin
                        bus.mem_req_valid <= 1'b0;
                        timer             <= TMR_LOAD;
                        state             <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    // Data arriving on the last allowed cycle still wins over the timeout.
                    if (bus.mem_rvalid) begin
                        data_q       <= bus.mem_rdata;
                        bus.cache_we <= 1'b1;
                        state        <= FILL;
                    end else if (timer == '0) begin
                        bus.resp_data  <= '0;
                        bus.resp_err   <= 1'b1;
                        bus.resp_valid <= 1'b1;
                        state          <= RESP;
                    end else begin
                        timer <= timer - TMR_WIDTH'(1);
                    end
                end
                FILL: begin
                    bus.resp_data  <= data_q;
                    bus.resp_err   <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: begin
                    bus.resp_valid    <= 1'b0;
                    bus.mem_req_valid <= 1'b0;
                    bus.req_ready     <= 1'b1;
                    state             <= IDLE;
                end
            endcase
        end
    end
endmodule
